// File: rtl/uart_adder_host.sv
// Host-side requester for the UART adder link: sends A,B as four bytes (MSB first)
// and assembles the two-byte reply into a 16-bit result.
module uart_adder_host #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TMR_W          = 17
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start_in,
  input  logic [15:0] A_in,
  input  logic [15:0] B_in,
  input  logic        Tx_Done_in,
  output logic        Tx_DV_out,
  output logic [7:0]  Tx_Byte_out,
  input  logic        Rx_DV_in,
  input  logic [7:0]  Rx_Byte_in,
  output logic        Busy_out,
  output logic [15:0] Result_out,
  output logic        Result_valid_out,
  output logic        Timeout_out
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_TX, S_RECV, S_DONE} state_e;

  // The abort decision is taken one cycle early so the registered Timeout_out
  // lands exactly TIMEOUT_CYCLES cycles after the last received byte.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              rx_cnt_q, rx_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [31:0]       op_q, op_d;
  logic [7:0]        res_msb_q, res_msb_d;
  logic [15:0]       result_q, result_d;
  logic              timeout_q, timeout_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      rx_cnt_q   <= 1'b0;
      timer_q    <= '0;
      op_q       <= 32'd0;
      res_msb_q  <= 8'd0;
      result_q   <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      rx_cnt_q   <= rx_cnt_d;
      timer_q    <= timer_d;
      op_q       <= op_d;
      res_msb_q  <= res_msb_d;
      result_q   <= result_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    rx_cnt_d   = rx_cnt_q;
    timer_d    = timer_q;
    op_d       = op_q;
    res_msb_d  = res_msb_q;
    result_d   = result_q;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start_in) begin
          op_d       = {A_in, B_in};
          byte_idx_d = 2'd0;
          state_d    = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (Tx_Done_in) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_SEND;
          end else begin
            rx_cnt_d = 1'b0;
            timer_d  = '0;
            state_d  = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (Rx_DV_in) begin
          if (!rx_cnt_q) begin
            res_msb_d = Rx_Byte_in;
            rx_cnt_d  = 1'b1;
            timer_d   = '0;
          end else begin
            result_d = {res_msb_q, Rx_Byte_in};
            state_d  = S_DONE;
          end
        end else if (timer_q == TMR_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (byte_idx_q)
      2'd0:    Tx_Byte_out = op_q[31:24];
      2'd1:    Tx_Byte_out = op_q[23:16];
      2'd2:    Tx_Byte_out = op_q[15:8];
      default: Tx_Byte_out = op_q[7:0];
    endcase
  end

  assign Tx_DV_out        = (state_q == S_SEND);
  assign Busy_out         = (state_q != S_IDLE);
  assign Result_valid_out = (state_q == S_DONE);
  assign Result_out       = result_q;
  assign Timeout_out      = timeout_q;

endmodule

// File: tb/tb_uart_adder_host.sv
// Self-checking bench for uart_adder_host: scripted UART TX/RX responder with
// randomized operands/replies checked against a byte-level reference model.
module tb_uart_adder_host;
  localparam int TO = 50;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start_in = 1'b0;
  logic [15:0] A_in = 16'd0, B_in = 16'd0;
  logic        Tx_Done_in = 1'b0;
  logic        Tx_DV_out;
  logic [7:0]  Tx_Byte_out;
  logic        Rx_DV_in = 1'b0;
  logic [7:0]  Rx_Byte_in = 8'd0;
  logic        Busy_out;
  logic [15:0] Result_out;
  logic        Result_valid_out;
  logic        Timeout_out;

  int checks = 0;
  int errors = 0;
  int tx_dv_cnt = 0, rv_cnt = 0, to_cnt = 0;
  logic [15:0] model_result = 16'd0;

  uart_adder_host #(.TIMEOUT_CYCLES(TO), .TMR_W(17)) dut (
    .CLK(CLK), .RST(RST), .Start_in(Start_in), .A_in(A_in), .B_in(B_in),
    .Tx_Done_in(Tx_Done_in), .Tx_DV_out(Tx_DV_out), .Tx_Byte_out(Tx_Byte_out),
    .Rx_DV_in(Rx_DV_in), .Rx_Byte_in(Rx_Byte_in), .Busy_out(Busy_out),
    .Result_out(Result_out), .Result_valid_out(Result_valid_out),
    .Timeout_out(Timeout_out)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (Tx_DV_out)        tx_dv_cnt <= tx_dv_cnt + 1;
    if (Result_valid_out) rv_cnt    <= rv_cnt + 1;
    if (Timeout_out)      to_cnt    <= to_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Start a request and act as the UART TX: Tx_Done 10 cycles after each Tx_DV.
  task automatic send_ops(input logic [15:0] a, input logic [15:0] b, input bit inject);
    logic [31:0] w;
    logic [7:0]  exp_b;
    int base;
    w = {a, b};
    base = tx_dv_cnt;
    Start_in = 1'b1; A_in = a; B_in = b;
    tick();
    Start_in = 1'b0; A_in = 16'($urandom); B_in = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      exp_b = w[31 - 8*i -: 8];
      checks++;
      if (Tx_DV_out !== 1'b1 || Tx_Byte_out !== exp_b) begin
        errors++;
        $display("FAIL tx_byte%0d: dv=%b byte=%h, want dv=1 byte=%h", i, Tx_DV_out, Tx_Byte_out, exp_b);
      end
      tick();
      for (int j = 0; j < 9; j++) begin
        if (inject && i == 1 && j == 3) begin
          Start_in = 1'b1; A_in = 16'hDEAD; B_in = 16'hBEEF;
          Rx_DV_in = 1'b1; Rx_Byte_in = 8'hAA;
        end
        tick();
        Start_in = 1'b0; Rx_DV_in = 1'b0;
      end
      checks++;
      if (Tx_DV_out !== 1'b0 || Tx_Byte_out !== exp_b || Busy_out !== 1'b1) begin
        errors++;
        $display("FAIL tx_hold%0d: dv=%b byte=%h busy=%b, want dv=0 byte=%h busy=1",
                 i, Tx_DV_out, Tx_Byte_out, Busy_out, exp_b);
      end
      Tx_Done_in = 1'b1;
      tick();
      Tx_Done_in = 1'b0;
    end
    checks++;
    if (tx_dv_cnt - base != 4) begin
      errors++;
      $display("FAIL tx_count: got %0d Tx_DV pulses, want 4", tx_dv_cnt - base);
    end
  endtask

  // Act as the UART RX; ends in the first IDLE cycle after DONE.
  task automatic recv(input logic [7:0] r0, input logic [7:0] r1, input int gap0, input int gap1);
    int base_rv, base_to;
    base_rv = rv_cnt; base_to = to_cnt;
    repeat (gap0) tick();
    Rx_DV_in = 1'b1; Rx_Byte_in = r0;
    tick();
    Rx_DV_in = 1'b0; Rx_Byte_in = 8'($urandom);
    repeat (gap1) tick();
    Rx_DV_in = 1'b1; Rx_Byte_in = r1;
    tick();
    Rx_DV_in = 1'b0; Rx_Byte_in = 8'($urandom);
    model_result = (16'(r0) << 8) | 16'(r1);
    checks++;
    if (Result_valid_out !== 1'b1 || Result_out !== model_result || Busy_out !== 1'b1) begin
      errors++;
      $display("FAIL result: valid=%b res=%h busy=%b, want valid=1 res=%h busy=1",
               Result_valid_out, Result_out, Busy_out, model_result);
    end
    tick();
    checks++;
    if (Result_valid_out !== 1'b0 || Busy_out !== 1'b0 || Result_out !== model_result ||
        rv_cnt - base_rv != 1 || to_cnt != base_to) begin
      errors++;
      $display("FAIL post_result: valid=%b busy=%b res=%h pulses=%0d to=%0d, want 0 0 %h 1 0",
               Result_valid_out, Busy_out, Result_out, rv_cnt - base_rv, to_cnt - base_to, model_result);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (Tx_DV_out !== 1'b0 || Tx_Byte_out !== 8'h00 || Busy_out !== 1'b0 ||
        Result_out !== 16'h0000 || Result_valid_out !== 1'b0 || Timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: dv=%b byte=%h busy=%b res=%h rv=%b to=%b, want all 0",
               Tx_DV_out, Tx_Byte_out, Busy_out, Result_out, Result_valid_out, Timeout_out);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    send_ops(16'h0180, 16'h0240, 1'b0);
    recv(8'h03, 8'hC0, 3, 5);
  endtask

  task automatic test_signed();
    send_ops(16'hFF00, 16'h0080, 1'b0);
    recv(8'hFF, 8'h80, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      send_ops(16'($urandom), 16'($urandom), 1'b0);
      recv(8'($urandom), 8'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_timeout();
    logic [15:0] prior;
    int n, base_rv;
    prior = model_result;
    base_rv = rv_cnt;
    send_ops(16'($urandom), 16'($urandom), 1'b0);
    Rx_DV_in = 1'b1; Rx_Byte_in = 8'h12;
    tick();
    Rx_DV_in = 1'b0;
    n = 1;
    while (Timeout_out !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL timeout_latency: pulse %0d cycles after byte, want %0d", n, TO);
    end
    checks++;
    if (Result_out !== prior || Busy_out !== 1'b0 || rv_cnt != base_rv) begin
      errors++;
      $display("FAIL timeout_state: res=%h busy=%b rv=%0d, want res=%h busy=0 rv=0",
               Result_out, Busy_out, rv_cnt - base_rv, prior);
    end
    tick();
    checks++;
    if (Timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: Timeout_out=%b one cycle later, want 0", Timeout_out);
    end
    // Second byte lands in the very cycle the timer would expire: must count as data.
    send_ops(16'($urandom), 16'($urandom), 1'b0);
    recv(8'($urandom), 8'($urandom), 0, TO - 2);
  endtask

  task automatic test_ignore();
    send_ops(16'h1234, 16'h5678, 1'b1);
    recv(8'h5A, 8'hC3, 2, 2);
  endtask

  task automatic test_reset_midop();
    int base_rv, base_to;
    base_rv = rv_cnt; base_to = to_cnt;
    Start_in = 1'b1; A_in = 16'($urandom); B_in = 16'($urandom);
    tick();
    Start_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      repeat (3) tick();
      Tx_Done_in = 1'b1;
      tick();
      Tx_Done_in = 1'b0;
    end
    checks++;
    if (Tx_DV_out !== 1'b1) begin
      errors++;
      $display("FAIL midop_setup: Tx_DV_out=%b before reset, want 1", Tx_DV_out);
    end
    #2 RST = 1'b0;
    #1;
    model_result = 16'h0000;
    checks++;
    if (Tx_DV_out !== 1'b0 || Tx_Byte_out !== 8'h00 || Busy_out !== 1'b0 ||
        Result_out !== 16'h0000 || Result_valid_out !== 1'b0 || Timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: dv=%b byte=%h busy=%b res=%h rv=%b to=%b, want all 0",
               Tx_DV_out, Tx_Byte_out, Busy_out, Result_out, Result_valid_out, Timeout_out);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    tick();
    checks++;
    if (rv_cnt != base_rv || to_cnt != base_to || Busy_out !== 1'b0) begin
      errors++;
      $display("FAIL midop_pulses: rv=%0d to=%0d busy=%b after reset, want 0 0 0",
               rv_cnt - base_rv, to_cnt - base_to, Busy_out);
    end
    send_ops(16'h0001, 16'h0002, 1'b0);
    recv(8'($urandom), 8'($urandom), 1, 1);
  endtask

  task automatic test_back_to_back();
    send_ops(16'($urandom), 16'($urandom), 1'b0);
    recv(8'($urandom), 8'($urandom), 0, 1);
    send_ops(16'hA55A, 16'h0F0F, 1'b0);
    recv(8'h77, 8'h88, 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_random();
    test_timeout();
    test_ignore();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_adder_host.md
Name: uart_adder_host

Overview:
Host-side requester for the UART fixed-point adder link. It accepts two 16-bit operands on a parallel interface and serializes them as four bytes to a UART TX: A MSB, A LSB, B MSB, B LSB. It then collects the two-byte result (MSB first) from a UART RX and presents it as one 16-bit word. It is used on the test-host FPGA and as the bench driver for the adder core.

Parameters:
TIMEOUT_CYCLES, 100000, max cycles in RECV without a received byte before abort (must be >=2)
TMR_W, 17, width of the timeout counter (must hold TIMEOUT_CYCLES-1)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous active-low reset
Start_in  in  1  request pulse; sampled only in IDLE
A_in  in  16  operand A; captured when Start_in is accepted
B_in  in  16  operand B; captured when Start_in is accepted
Tx_Done_in  in  1  one-cycle pulse from UART TX: byte fully sent
Tx_DV_out  out  1  one-cycle pulse: start transmitting Tx_Byte_out
Tx_Byte_out  out  8  byte to transmit; stable from Tx_DV_out until the matching Tx_Done_in
Rx_DV_in  in  1  one-cycle pulse from UART RX: Rx_Byte_in valid
Rx_Byte_in  in  8  received byte
Busy_out  out  1  high in every state except IDLE
Result_out  out  16  last completed result; held between transactions
Result_valid_out  out  1  one-cycle pulse when Result_out updates
Timeout_out  out  1  one-cycle pulse when the response is aborted

Behaviour:
- Reset (RST=0, asynchronous) forces:
  - state IDLE
  - byte_idx=0, rx_cnt=0, timer=0
  - operand registers=0
  - all outputs 0 (Tx_Byte_out=0x00, Result_out=0x0000)
- States: IDLE, SEND, WAIT_TX, RECV, DONE. Outputs are registered or Moore-decoded; no combinational path from any input to any output.
- IDLE:
  - Start_in=1: latch {A_in,B_in}, byte_idx<=0, go to SEND.
  - Rx_DV_in and Tx_Done_in are ignored.
- SEND (exactly 1 cycle):
  - Tx_DV_out=1.
  - Tx_Byte_out = A[15:8], A[7:0], B[15:8], B[7:0] for byte_idx 0..3.
  - Go to WAIT_TX.
  - A Tx_Done_in arriving in SEND is ignored.
- WAIT_TX:
  - Wait for Tx_Done_in.
  - If byte_idx<3: byte_idx++, go to SEND.
  - If byte_idx==3: rx_cnt<=0, timer<=0, go to RECV.
  - No timeout in WAIT_TX.
- Latency: first Tx_DV_out occurs the cycle after Start_in is sampled. Each later Tx_DV_out occurs the cycle after the preceding Tx_Done_in.
- RECV:
  - Rx_DV_in with rx_cnt==0: res_msb<=Rx_Byte_in, rx_cnt<=1, timer<=0.
  - Rx_DV_in with rx_cnt==1: Result_out<={res_msb,Rx_Byte_in}, go to DONE.
  - No Rx_DV_in: timer++. When timer==TIMEOUT_CYCLES-1 and no Rx_DV_in this cycle: Timeout_out=1 for 1 cycle, go to IDLE. Result_out is unchanged.
  - Rx_DV_in in the same cycle the timer expires counts as a byte received, not a timeout.
- DONE (1 cycle): Result_valid_out=1, go to IDLE. Result_valid_out rises the cycle after the second Rx_DV_in.
- Rx bytes arriving outside RECV (including during SEND/WAIT_TX) are discarded.
- Start_in while Busy_out=1 is ignored and not queued.
- Start_in is accepted in the first IDLE cycle after DONE or a timeout, so transactions can run back-to-back.
- Reset mid-transaction aborts immediately:
  - no Result_valid_out or Timeout_out is produced
  - Tx_DV_out drops asynchronously with RST
- Result is passed through unmodified: no arithmetic, no sign handling; signed interpretation is left to the consumer.

Test Plan:
- Basic: A=0x0180, B=0x0240, Start pulse; UART model returns Tx_Done 10 cycles after each Tx_DV -> Tx bytes 0x01,0x80,0x02,0x40 in order, one Tx_DV each; RX replies 0x03,0xC0 -> Result_out=0x03C0, one Result_valid pulse one cycle after the second Rx_DV.
- Signed: A=0xFF00, B=0x0080; RX replies 0xFF,0x80 -> Result_out=0xFF80; Busy_out low the cycle after Result_valid.
- Timeout: TIMEOUT_CYCLES=50; after 4 bytes, send only 0x12 -> Timeout_out pulses exactly 50 cycles after the 0x12 byte; Result_out keeps its prior value; Busy_out=0.
- Ignore rules: Start pulsed during WAIT_TX, and Rx_DV with 0xAA injected during WAIT_TX -> still exactly 4 Tx bytes; the 0xAA is not captured; result is built only from the 2 bytes received in RECV.
- Reset mid-op: assert RST after the 2nd Tx_Done -> all outputs 0 immediately; after release, a new Start with A=0x0001, B=0x0002 sends 0x00,0x01,0x00,0x02.
- Back-to-back: Start asserted in the IDLE cycle right after Result_valid -> Tx_DV the following cycle with the new A MSB.
